// File: rtl/attn_spike_packer_if.sv
// Stream bundle between the popcount adders, the spike packer and its consumer.
// The master side feeds partial sums and accepts spike words; the slave side is the packer.
interface attn_spike_packer_if #(
  parameter int SUM_W  = 4,
  parameter int WORD_W = 8
);
  logic              i_sum_valid;
  logic [SUM_W-1:0]  i_sum;
  logic              i_sum_last;
  logic              o_sum_ready;
  logic              o_spikes_valid;
  logic [WORD_W-1:0] o_spikes;
  logic              o_spikes_last;
  logic              i_spikes_ready;

  modport master (
    output i_sum_valid, i_sum, i_sum_last, i_spikes_ready,
    input  o_sum_ready, o_spikes_valid, o_spikes, o_spikes_last
  );

  modport slave (
    input  i_sum_valid, i_sum, i_sum_last, i_spikes_ready,
    output o_sum_ready, o_spikes_valid, o_spikes, o_spikes_last
  );
endinterface

// File: rtl/attn_spike_packer.sv
// Accumulates NUM_SUMS partial popcounts per neuron, thresholds each total into a spike
// and packs spikes LSB-first into WORD_W-bit words behind a single holding register.
module attn_spike_packer #(
  parameter int SUM_W    = 4,
  parameter int NUM_SUMS = 16,
  parameter int ACC_W    = SUM_W + $clog2(NUM_SUMS) + 1,
  parameter int VTH      = 8,
  parameter int WORD_W   = 8
) (
  input logic                s_clk,
  input logic                s_rst,
  attn_spike_packer_if.slave bus
);
  localparam int CNT_W = (NUM_SUMS > 1) ? $clog2(NUM_SUMS) : 1;
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_SUMS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORD_W - 1);

  logic [ACC_W-1:0]  acc, total;
  logic [CNT_W-1:0]  sum_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] pack_reg, word_nxt, out_word;
  logic              out_vld, out_last;
  logic              take, nfinal, spike, flush;

  assign bus.o_sum_ready    = !out_vld | bus.i_spikes_ready;
  assign bus.o_spikes_valid = out_vld;
  assign bus.o_spikes       = out_word;
  assign bus.o_spikes_last  = out_last;

  assign take   = bus.i_sum_valid & bus.o_sum_ready;
  assign nfinal = (sum_cnt == CNT_MAX);
  assign total  = acc + ACC_W'(bus.i_sum);
  assign spike  = (total >= ACC_W'(VTH));
  assign flush  = take & nfinal & ((bit_idx == IDX_MAX) | bus.i_sum_last);

  // Word as it would look with the new spike inserted; bits above bit_idx are padding.
  always_comb begin
    word_nxt = '0;
    for (int k = 0; k < WORD_W; k++) begin
      if (IDX_W'(k) < bit_idx)       word_nxt[k] = pack_reg[k];
      else if (IDX_W'(k) == bit_idx) word_nxt[k] = spike;
    end
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      acc      <= '0;
      sum_cnt  <= '0;
      bit_idx  <= '0;
      pack_reg <= '0;
      out_vld  <= 1'b0;
      out_word <= '0;
      out_last <= 1'b0;
    end else begin
      if (take) begin
        if (nfinal) begin
          acc     <= '0;
          sum_cnt <= '0;
          if (flush) begin
            pack_reg <= '0;
            bit_idx  <= '0;
          end else begin
            pack_reg[bit_idx] <= spike;
            bit_idx           <= bit_idx + 1'b1;
          end
        end else begin
          acc     <= total;
          sum_cnt <= sum_cnt + 1'b1;
        end
      end
      // A fresh load wins over the transfer of the held word, so there is no bubble.
      if (flush) begin
        out_vld  <= 1'b1;
        out_word <= word_nxt;
        out_last <= bus.i_sum_last;
      end else if (out_vld & bus.i_spikes_ready) begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_attn_spike_packer.sv
// Directed + randomized bench for attn_spike_packer with a queue-based reference model.
module tb_attn_spike_packer;
  localparam int NS  = 4;
  localparam int VTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  attn_spike_packer_if #(.SUM_W(4), .WORD_W(8)) bus ();

  attn_spike_packer #(.SUM_W(4), .NUM_SUMS(NS), .VTH(VTH), .WORD_W(8)) dut (
    .s_clk (clk),
    .s_rst (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: sums of the current neuron, spikes of the current word, expected words.
  int         nq[$];
  bit         bq[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_clear();
    nq.delete();
    bq.delete();
    exp_q.delete();
  endfunction

  function automatic void model_accept(input int s, input bit l);
    int         tot;
    logic [7:0] w;
    nq.push_back(s);
    if (nq.size() == NS) begin
      tot = nq.sum();
      nq.delete();
      bq.push_back(tot >= VTH);
      if (bq.size() == 8 || l) begin
        w = '0;
        for (int k = 0; k < bq.size(); k++) w[k] = bq[k];
        exp_q.push_back({l, w});
        bq.delete();
      end
    end
  endfunction

  // One cycle: drive at the falling edge, check after 1 time unit, return at the next falling edge.
  task automatic drive(input bit v, input int s, input bit l, input bit rdy, output bit acc);
    bit pend;
    bus.i_sum_valid    = v;
    bus.i_sum          = 4'(s);
    bus.i_sum_last     = l;
    bus.i_spikes_ready = rdy;
    #1;
    pend = (exp_q.size() != 0);
    chk("sum_ready", bus.o_sum_ready, !pend || rdy);
    chk("spikes_valid", bus.o_spikes_valid, pend);
    if (pend) chk("word", {bus.o_spikes_last, bus.o_spikes}, exp_q[0]);
    acc = v && (!pend || rdy);
    if (pend && rdy) void'(exp_q.pop_front());
    if (acc) model_accept(s, l);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int s, input bit l, input bit rdy, input bit rnd);
    bit a;
    bit r;
    int n;
    n = 0;
    a = 1'b0;
    while (!a && n < 40) begin
      r = rnd ? ($urandom_range(0, 3) != 0) : rdy;
      drive(1'b1, s, l, r, a);
      n++;
    end
    if (!a) chk("accept_timeout", a, 1);
  endtask

  task automatic neuron(input int a, input int b, input int c, input int d, input bit l, input bit rdy);
    send(a, 1'b0, rdy, 1'b0);
    send(b, 1'b0, rdy, 1'b0);
    send(c, 1'b0, rdy, 1'b0);
    send(d, l, rdy, 1'b0);
  endtask

  task automatic rand_neuron(input bit may_last);
    for (int i = 0; i < NS; i++)
      send($urandom_range(0, 8), (i == NS - 1) && may_last && ($urandom_range(0, 7) == 0), 1'b1, 1'b1);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) drive(1'b0, 0, 1'b0, 1'b1, a);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit a;
    bus.i_sum_valid    = 1'b0;
    bus.i_sum          = '0;
    bus.i_sum_last     = 1'b0;
    bus.i_spikes_ready = 1'b0;
    #12;
    chk("rst_valid", bus.o_spikes_valid, 0);
    chk("rst_spikes", bus.o_spikes, 0);
    chk("rst_last", bus.o_spikes_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", bus.o_sum_ready, 1);
    chk("idle_valid", bus.o_spikes_valid, 0);
    chk("idle_spikes", bus.o_spikes, 0);
    @(negedge clk);

    // Threshold edge: total == VTH fires; word held with downstream stalled.
    for (int n = 0; n < 8; n++) neuron(2, 2, 2, 2, 1'b0, 1'b0);
    chk("ff_latency", {bus.o_spikes_valid, bus.o_spikes_last, bus.o_spikes}, 10'h2FF);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3, 1'b0, 1'b0, a);
      chk("bp_no_accept", a, 0);
      chk("bp_hold", bus.o_spikes, 8'hFF);
    end
    drive(1'b0, 0, 1'b0, 1'b1, a);

    // One below threshold never fires.
    for (int n = 0; n < 8; n++) neuron(2, 2, 2, 1, 1'b0, 1'b1);
    chk("below_vth", {bus.o_spikes_valid, bus.o_spikes}, 9'h100);

    // Alternating fire/no-fire shows LSB-first packing.
    for (int n = 0; n < 4; n++) begin
      neuron(8, 0, 0, 0, 1'b0, 1'b1);
      neuron(0, 0, 0, 0, 1'b0, 1'b1);
    end
    chk("pattern_55", bus.o_spikes, 8'h55);

    // Partial row flush with zero padding, then a fresh row from bit 0.
    neuron(3, 3, 3, 0, 1'b0, 1'b1);
    neuron(1, 1, 1, 0, 1'b0, 1'b1);
    neuron(3, 3, 3, 3, 1'b1, 1'b1);
    chk("flush_word", {bus.o_spikes_valid, bus.o_spikes_last, bus.o_spikes}, 10'h305);
    for (int n = 0; n < 4; n++) neuron(4, 4, 0, 0, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) neuron(1, 1, 1, 1, 1'b0, 1'b1);
    chk("next_row", {bus.o_spikes_last, bus.o_spikes}, 9'h00F);

    // Random sums, random row ends, random downstream stalls.
    for (int n = 0; n < 60; n++) rand_neuron(1'b1);
    drain();

    // Async reset in the middle of neuron 5.
    for (int n = 0; n < 5; n++) rand_neuron(1'b0);
    send(5, 1'b0, 1'b1, 1'b0);
    send(6, 1'b0, 1'b1, 1'b0);
    bus.i_spikes_ready = 1'b0;
    bus.i_sum_valid    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.o_spikes_valid, 0);
    chk("arst_spikes", bus.o_spikes, 0);
    chk("arst_last", bus.o_spikes_last, 0);
    chk("arst_ready", bus.o_sum_ready, 1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) rand_neuron(1'b1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/attn_spike_packer.md
Name: attn_spike_packer

Overview:
- Sits after the 8-input popcount adder groups in the attention-calculation path.
- Accepts a stream of 4-bit partial popcount sums and accumulates NUM_SUMS of them per output neuron.
- Thresholds each neuron's total into one spike bit and packs consecutive spikes LSB-first into 8-bit spike words.
- The 8-bit words are the same format the popcount stage consumes, so this block closes the loop spike-word → count → spike-word.

Parameters:
- SUM_W, 4: width of each incoming partial sum.
- NUM_SUMS, 16: partial sums per neuron; ≥1.
- ACC_W, SUM_W+$clog2(NUM_SUMS)+1: accumulator width; never overflows.
- VTH, 8: firing threshold; spike = total ≥ VTH, unsigned compare.
- WORD_W, 8: spikes per output word.

Ports:
- s_clk, input, 1: clock, rising edge.
- s_rst, input, 1: asynchronous active-low reset.
- i_sum_valid, input, 1: i_sum valid.
- i_sum, input, SUM_W: partial popcount sum, 0..8.
- i_sum_last, input, 1: marks the final sum of the final neuron of a row.
- o_sum_ready, output, 1: block can accept i_sum this cycle.
- o_spikes_valid, output, 1: output word valid.
- o_spikes, output, WORD_W: packed spikes; bit k = k-th neuron of the word.
- o_spikes_last, output, 1: word is the final (possibly partial) word of a row.
- i_spikes_ready, input, 1: downstream accepts the word.

Behaviour:
- Reset (async assert, sync release):
  - acc, sum_cnt, bit_idx, pack_reg = 0.
  - o_spikes_valid = 0, o_spikes = 0, o_spikes_last = 0.
  - Reset mid-operation discards partial accumulations and any held word; no word is emitted for it.
- Handshake:
  - Input transfer: i_sum_valid & o_sum_ready at a rising edge.
  - Output transfer: o_spikes_valid & i_spikes_ready.
  - o_sum_ready = !o_spikes_valid | i_spikes_ready (combinational, single output holding register); it equals 1 out of reset.
  - While o_spikes_valid=1, o_spikes and o_spikes_last hold stable until transfer.
- Accumulate (each input transfer):
  - If sum_cnt < NUM_SUMS-1: acc += i_sum; sum_cnt++.
  - If sum_cnt == NUM_SUMS-1 (neuron-final sum):
    - total = acc + i_sum (ACC_W wide).
    - spike = (total ≥ VTH).
    - pack_reg[bit_idx] = spike.
    - acc = 0, sum_cnt = 0.
- Packing:
  - On a neuron-final sum, if bit_idx == WORD_W-1 or i_sum_last=1:
    - Load o_spikes = pack_reg with the new spike inserted; bits above bit_idx are forced to 0 (zero padding).
    - o_spikes_last = i_sum_last.
    - o_spikes_valid = 1 on the next cycle.
    - pack_reg = 0, bit_idx = 0.
  - Otherwise bit_idx++.
- i_sum_last is sampled only on a neuron-final sum; it is ignored on other sums.
- Latency: from the neuron-final sum transfer that completes a word to o_spikes_valid = 1 cycle.
- Throughput: one sum per cycle sustained when i_spikes_ready=1.
- Simultaneous events:
  - Output transfer and a new word load in the same cycle: the new word replaces the old one and o_spikes_valid stays 1; no bubble, no loss.
  - Backpressure: o_spikes_valid=1 & i_spikes_ready=0 → o_sum_ready=0 and all state holds.
- NUM_SUMS=1: every sum is neuron-final.
- Boundary value: total == VTH → spike=1. Maximum total = 8·NUM_SUMS, representable in ACC_W.

Test Plan:
- Reset/idle (NUM_SUMS=4, VTH=8): release reset, no input → o_sum_ready=1, o_spikes_valid=0, o_spikes=0x00.
- Threshold edge:
  - 8 neurons with sums {2,2,2,2}: total 8 → word 0xFF, o_spikes_last=0, 1 cycle after the 32nd transfer.
  - Same with {2,2,2,1}: total 7 → 0x00.
- Pattern packing: neurons 0..7 totals alternating 8,0 (sums {8,0,0,0} / {0,0,0,0}) → o_spikes=0x55, confirming LSB-first order.
- Partial flush:
  - 3 neurons, totals 9,3,12, i_sum_last on the 12th sum → o_spikes=0x05, o_spikes_last=1.
  - Next row starts at bit_idx 0.
- Backpressure:
  - Hold i_spikes_ready=0 with a word pending; continuous i_sum_valid → o_sum_ready=0, no acc change.
  - Word stays 0xFF until ready=1.
  - Then back-to-back words with no lost sums; totals verified by scoreboard.
- Async reset mid-neuron: assert s_rst after 2 of 4 sums of neuron 5 → all outputs 0 immediately; post-reset stream produces words matching a fresh model.
